status_flag_unit: RTL and testbench
===================================

# status_flag_unit

Parametrised successor to the single ARM32 status register: holds the NZCV-bearing status word with a per-bit write mask, same-cycle forwarding, and a DEPTH-entry save/restore stack for exception entry/return. It also evaluates the ARM condition field against the forwarded flags. It sits between the ALU flag outputs and the execute-stage condition check.

## Interface
- WIDTH, 32: status word width.
- FLAG_LSB, 28: bit position of V. C is FLAG_LSB+1, Z is FLAG_LSB+2, N is FLAG_LSB+3. WIDTH must be at least FLAG_LSB+4.
- DEPTH, 4: save stack entries, minimum 1.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en_status  in  1  write status_in into the register under flag_mask.
- flag_mask  in  WIDTH  per-bit write enable; 1 means the bit takes status_in.
- status_in  in  WIDTH  new flags from the ALU.
- status_rdy  in  1  forward the merged value to status_out this cycle.
- save  in  1  push onto the save stack.
- restore  in  1  pop the save stack into the register.
- cond  in  4  ARM condition code.
- status_out  out  WIDTH  current (or forwarded) status.
- cond_pass  out  1  cond evaluated on status_out.
- stack_cnt  out  $clog2(DEPTH+1)  number of occupied entries.
- stack_full  out  1  stack_cnt == DEPTH.
- stack_empty  out  1  stack_cnt == 0.
- ovf  out  1  registered one-cycle pulse: save was refused.
- udf  out  1  registered one-cycle pulse: restore was refused.

## Operation
- merged = en_status ? ((status_reg & ~flag_mask) | (status_in & flag_mask)) : status_reg.
- status_out = status_rdy ? merged : status_reg. This path is combinational.
- cond_pass is combinational on the status_out N, Z, C, V bits:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C & !Z. 9 LS: !C | Z.
  - 10 GE: N == V. 11 LT: N != V.
  - 12 GT: !Z & (N == V). 13 LE: Z | (N != V).
  - 14 and 15: 1.
- Per cycle, evaluated in this order:
  - save & restore, stack non-empty: exchange. status_reg <= top entry; top entry <= merged; stack_cnt unchanged.
  - save & restore, stack empty: udf pulses. status_reg <= merged. No push.
  - restore only, non-empty: status_reg <= top entry; pop. en_status is ignored.
  - restore only, empty: udf pulses; status_reg <= merged.
  - save only, not full: push merged; status_reg <= merged.
  - save only, full: ovf pulses; no push; status_reg <= merged.
  - neither: status_reg <= merged.
- Stack is LIFO: entry index stack_cnt-1 is the top.
- Bits outside flag_mask are never modified by a write.

## Timing
- Reset (asynchronous, immediate):
  - status_reg = 0, stack_cnt = 0, all stack entries = 0.
  - stack_empty = 1, stack_full = 0, ovf = 0, udf = 0.
  - Outputs settle to these values without a clock edge.
- Write latency: 1 cycle to status_reg. Forwarding via status_rdy has 0 latency.
- Save/restore: stack_cnt, stack_full and stack_empty update on the edge that performs the push or pop.
- ovf and udf assert on the edge after the refused request, for exactly 1 cycle.
- Back-to-back save or restore every cycle is supported with no bubbles.
- Reset asserted mid-sequence discards all stack contents; the first request after release sees an empty stack.

## Test plan
- Masked write: reset; en_status=1, flag_mask=0xF0000000, status_in=0xFFFFFFFF. Next cycle status_out=0xF0000000 and cond 0 (EQ) gives cond_pass=1.
- Forwarding: status_reg=0; status_rdy=1, en_status=1, mask all ones, status_in=0x40000000. Same cycle status_out=0x40000000 and cond_pass(EQ)=1. After the edge, with status_rdy=0, status_out=0x40000000.
- Stack fill/drain, DEPTH=4: save with values 0x1, 0x2, 0x3, 0x4 written in the same cycles. stack_full=1. A 5th save gives ovf pulse, stack_cnt=4. Four restores return 0x4, 0x3, 0x2, 0x1. A 5th restore gives udf pulse and status_out is unchanged.
- Exchange: stack top=0x80000000, status_reg=0x20000000; save=restore=1 with en_status=0. Next cycle status_out=0x80000000, top entry=0x20000000, stack_cnt unchanged.
- Condition sweep: load N=1, Z=0, C=1, V=0. Required cond_pass values:
  - GE=0, LT=1, HI=1, LS=0, GT=0, LE=1, AL=1.
- Async reset mid-operation: with stack_cnt=2 and status_reg nonzero, pulse rst_n low between edges. Outputs are 0 immediately with stack_empty=1, and a following restore gives udf.

Source files
------------

// File: rtl/status_flag_if.sv
// status_flag_if
//   Groups the status/flag control and observation signals of
//   status_flag_unit. The master side (execute stage / test driver) drives
//   the write, forward, stack and condition inputs; the slave side (the
//   flag unit) returns the status word, condition result and stack state.
//
//   Parameters: WIDTH (status word width), DEPTH (save stack entries).
//   master: drives en_status, flag_mask, status_in, status_rdy, save,
//           restore and cond; observes every output.
//   slave:  the reverse of master.
interface status_flag_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             en_status;
  logic [WIDTH-1:0] flag_mask;
  logic [WIDTH-1:0] status_in;
  logic             status_rdy;
  logic             save;
  logic             restore;
  logic [3:0]       cond;
  logic [WIDTH-1:0] status_out;
  logic             cond_pass;
  logic [CNT_W-1:0] stack_cnt;
  logic             stack_full;
  logic             stack_empty;
  logic             ovf;
  logic             udf;

  modport master (
    output en_status, flag_mask, status_in, status_rdy, save, restore, cond,
    input  status_out, cond_pass, stack_cnt, stack_full, stack_empty, ovf, udf
  );

  modport slave (
    input  en_status, flag_mask, status_in, status_rdy, save, restore, cond,
    output status_out, cond_pass, stack_cnt, stack_full, stack_empty, ovf, udf
  );
endinterface

// File: rtl/status_flag_unit.sv
// status_flag_unit
//   NZCV-bearing status register with a per-bit write mask, same-cycle
//   forwarding of the merged value, a DEPTH-entry LIFO save/restore stack
//   for exception entry/return, and ARM condition-code evaluation on the
//   (possibly forwarded) flags.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    status_flag_if slave modport: write/forward/stack/cond inputs,
//            status_out, cond_pass, stack_cnt/full/empty, ovf/udf pulses.
module status_flag_unit #(
  parameter int WIDTH    = 32,
  parameter int FLAG_LSB = 28,
  parameter int DEPTH    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  status_flag_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH-1:0] merged;
  logic             full, empty;
  logic [IDX_W-1:0] top_idx, push_idx;
  logic             flag_n, flag_z, flag_c, flag_v;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  // Only meaningful when the stack is non-empty / not full respectively.
  assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign push_idx = IDX_W'(cnt_q);

  assign merged = bus.en_status
                ? ((status_q & ~bus.flag_mask) | (bus.status_in & bus.flag_mask))
                : status_q;

  // Forwarding path: the execute stage sees this cycle's ALU flags.
  assign bus.status_out = bus.status_rdy ? merged : status_q;

  assign flag_n = bus.status_out[FLAG_LSB+3];
  assign flag_z = bus.status_out[FLAG_LSB+2];
  assign flag_c = bus.status_out[FLAG_LSB+1];
  assign flag_v = bus.status_out[FLAG_LSB];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an uncovered case path infers a latch.
    bus.cond_pass = 1'b1;
    unique case (bus.cond)
      4'd0:    bus.cond_pass = flag_z;
      4'd1:    bus.cond_pass = !flag_z;
      4'd2:    bus.cond_pass = flag_c;
      4'd3:    bus.cond_pass = !flag_c;
      4'd4:    bus.cond_pass = flag_n;
      4'd5:    bus.cond_pass = !flag_n;
      4'd6:    bus.cond_pass = flag_v;
      4'd7:    bus.cond_pass = !flag_v;
      4'd8:    bus.cond_pass = flag_c && !flag_z;
      4'd9:    bus.cond_pass = !flag_c || flag_z;
      4'd10:   bus.cond_pass = (flag_n == flag_v);
      4'd11:   bus.cond_pass = (flag_n != flag_v);
      4'd12:   bus.cond_pass = !flag_z && (flag_n == flag_v);
      4'd13:   bus.cond_pass = flag_z || (flag_n != flag_v);
      default: bus.cond_pass = 1'b1;
    endcase
  end

  always_comb begin
    status_d = merged;
    stack_d  = stack_q;
    cnt_d    = cnt_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    if (bus.restore) begin
      if (!empty) begin
        // Restore wins over the ALU write; with save also set, the top
        // entry is swapped with the merged value instead of popped.
        status_d = stack_q[top_idx];
        if (bus.save) stack_d[top_idx] = merged;
        else          cnt_d = cnt_q - CNT_W'(1);
      end else begin
        udf_d = 1'b1;
      end
    end else if (bus.save) begin
      if (!full) begin
        stack_d[push_idx] = merged;
        cnt_d             = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      // NOTE: the stack array is reset too, so no stale exception context
      // survives a reset even though an empty stack never exposes it.
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      status_q <= status_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign bus.stack_cnt   = cnt_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.ovf         = ovf_q;
  assign bus.udf         = udf_q;
endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  status_flag_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  status_flag_unit #(.WIDTH(WIDTH), .FLAG_LSB(28), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_status;
  logic [31:0] m_stack [$];
  logic        m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic arm_cond(input logic [3:0] c, input logic [31:0] s);
    logic n, z, cy, v;
    n = s[31]; z = s[30]; cy = s[29]; v = s[28];
    case (c)
      0: return z;            1: return !z;
      2: return cy;           3: return !cy;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cy && !z;     9: return !cy || z;
      10: return n == v;      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] m_merged();
    if (bus.en_status)
      return (m_status & ~bus.flag_mask) | (bus.status_in & bus.flag_mask);
    return m_status;
  endfunction

  task automatic drive(input logic en, input logic [31:0] mask, input logic [31:0] din,
                       input logic rdy, input logic sv, input logic rs, input logic [3:0] cd);
    bus.en_status  = en;
    bus.flag_mask  = mask;
    bus.status_in  = din;
    bus.status_rdy = rdy;
    bus.save       = sv;
    bus.restore    = rs;
    bus.cond       = cd;
  endtask

  task automatic idle(input logic [3:0] cd);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, cd);
    #1;
  endtask

  task automatic model_check();
    logic [31:0] exp_out;
    exp_out = bus.status_rdy ? m_merged() : m_status;
    check("status_out", bus.status_out, exp_out);
    check("cond_pass", 32'(bus.cond_pass), 32'(arm_cond(bus.cond, exp_out)));
    check("stack_cnt", 32'(bus.stack_cnt), m_stack.size());
    check("stack_full", 32'(bus.stack_full), 32'(m_stack.size() == DEPTH));
    check("stack_empty", 32'(bus.stack_empty), 32'(m_stack.size() == 0));
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
    check("udf", 32'(bus.udf), 32'(m_udf));
  endtask

  // Advance one edge and apply the save/restore rules to the model.
  task automatic tick();
    logic [31:0] mg;
    int          n;
    @(posedge clk);
    mg = m_merged();
    n = m_stack.size();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    if (bus.restore && n > 0) begin
      m_status = m_stack[n-1];
      if (bus.save) m_stack[n-1] = mg;
      else void'(m_stack.pop_back());
    end else if (bus.restore) begin
      m_udf = 1'b1;
      m_status = mg;
    end else if (bus.save && n < DEPTH) begin
      m_stack.push_back(mg);
      m_status = mg;
    end else if (bus.save) begin
      m_ovf = 1'b1;
      m_status = mg;
    end else begin
      m_status = mg;
    end
    @(negedge clk);
  endtask

  task automatic cycle(input logic en, input logic [31:0] mask, input logic [31:0] din,
                       input logic rdy, input logic sv, input logic rs, input logic [3:0] cd);
    drive(en, mask, din, rdy, sv, rs, cd);
    #1;
    model_check();
    tick();
  endtask

  task automatic model_reset();
    m_status = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  logic [3:0] sweep_cond [7] = '{4'd10, 4'd11, 4'd8, 4'd9, 4'd12, 4'd13, 4'd14};
  logic       sweep_exp  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    model_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;
    check("reset_status", bus.status_out, 32'h0);
    check("reset_empty", 32'(bus.stack_empty), 32'd1);
    check("reset_full", 32'(bus.stack_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Masked write
    cycle(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(4'd0);
    check("masked_write", bus.status_out, 32'hF000_0000);
    check("masked_eq", 32'(bus.cond_pass), 32'd1);

    // Forwarding
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 32'hFFFF_FFFF, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    check("fwd_out", bus.status_out, 32'h4000_0000);
    check("fwd_eq", 32'(bus.cond_pass), 32'd1);
    model_check();
    tick();
    idle(4'd0);
    check("fwd_after", bus.status_out, 32'h4000_0000);

    // Stack fill / drain
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 32'hFFFF_FFFF, 32'(i), 1'b0, 1'b1, 1'b0, 4'd0);
    idle(4'd0);
    check("fill_full", 32'(bus.stack_full), 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    idle(4'd0);
    check("fill_ovf", 32'(bus.ovf), 32'd1);
    check("fill_cnt", 32'(bus.stack_cnt), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
      idle(4'd0);
      check("drain_val", bus.status_out, 32'(i));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    idle(4'd0);
    check("drain_udf", 32'(bus.udf), 32'd1);
    check("drain_hold", bus.status_out, 32'h1);

    // Exchange
    cycle(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd0);
    cycle(1'b1, 32'hFFFF_FFFF, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 4'd0);
    idle(4'd0);
    check("xchg_status", bus.status_out, 32'h8000_0000);
    check("xchg_cnt", 32'(bus.stack_cnt), 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    idle(4'd0);
    check("xchg_top", bus.status_out, 32'h2000_0000);

    // Condition sweep with N=1 Z=0 C=1 V=0
    cycle(1'b1, 32'hFFFF_FFFF, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      idle(sweep_cond[i]);
      check($sformatf("cond_%0d", sweep_cond[i]), 32'(bus.cond_pass), 32'(sweep_exp[i]));
    end

    // Async reset mid-operation
    cycle(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 4'd0);
    cycle(1'b1, 32'hFFFF_FFFF, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0, 4'd0);
    idle(4'd0);
    check("pre_rst_cnt", 32'(bus.stack_cnt), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_status", bus.status_out, 32'h0);
    check("rst_empty", 32'(bus.stack_empty), 32'd1);
    check("rst_cnt", 32'(bus.stack_cnt), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0);
    idle(4'd0);
    check("rst_udf", 32'(bus.udf), 32'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
